uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised serial transmitter; next generation of the switch/button-driven fixed 11-bit frame sender. Generalises data width, parity mode, stop-bit count and baud divisor. Adds a valid/ready input handshake with buffering, so words can be streamed back-to-back. Sits between the button/switch front end (or any word source) and the board TX pin.

Parameters:
CLK_DIV, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥2
DATA_W, 8, data bits per frame; legal range 5..9
PARITY, 1, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_DEPTH, 4, input buffer depth when UART_TX_FIFO_EN is defined; power of 2, ≥2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  buffer can accept; a transfer occurs on a rising edge where tx_valid && tx_ready
txd  output  1  serial line, idles high; registered
busy  output  1  high while a frame is on the line (state != IDLE); registered
frame_done  output  1  1-cycle pulse in the last clock cycle of the final stop bit
dbg_state  output  3  current FSM state encoding, for debug LEDs

Behaviour:
- Reset (rst low, asynchronous):
  - txd = 1, busy = 0, frame_done = 0.
  - FSM -> IDLE; buffer flushed; baud and bit counters cleared.
  - tx_ready forced 0 while rst is low.
  - Reset mid-frame aborts the frame immediately: txd returns high and buffered words are lost.
- Frame format: start (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
  - Frame length = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits; 8/even/1 gives 11 bits.
- Parity: computed from the word loaded into the shift register.
  - Even: parity bit = XOR of data bits.
  - Odd: parity bit = inverted XOR of data bits.
- Bit timing: an internal baud counter runs 0..CLK_DIV-1 and restarts at every frame start, so every bit, including the start bit, lasts exactly CLK_DIV clocks. No free-running enable.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: when the buffer is non-empty; the shift register loads and the buffer pops on that edge.
  - START -> DATA: after CLK_DIV clocks.
  - DATA -> PARITY (or STOP if PARITY = 0): after DATA_W bits; bit counter width = $clog2(DATA_W+1).
  - PARITY -> STOP: after one bit.
  - STOP -> START when the buffer is non-empty (back-to-back, zero idle gap); otherwise STOP -> IDLE. Taken after STOP_BITS bits.
- Latency: a word accepted at edge N, with the FSM in IDLE and the buffer empty, drives txd low from edge N+2.
- frame_done: asserted during the last clk cycle of the last stop bit, coincident with the STOP exit.
- tx_ready = !buffer_full (and rst high); purely a function of registered state.
- Push and pop on the same edge are both honoured; occupancy is unchanged.
- tx_data is sampled only on the accepting edge. Changes while tx_valid is high and tx_ready is low are ignored.

Optional Feature:
Macro: UART_TX_FIFO_EN.
- Defined: input buffer is a FIFO_DEPTH-entry circular FIFO with pointer wrap-around. Up to FIFO_DEPTH words are queued in addition to the word in the shift register.
- Undefined: buffer is a single holding register (effective depth 1) and FIFO_DEPTH is ignored. One word can be queued while another shifts out.
- Frame timing and serial output are identical in both builds.

Test Plan:
- Basic frame, CLK_DIV=4, 8/even/1: send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 clocks. txd low at accept+2. frame_done pulses once, 44 clocks after txd falls minus 1.
- Odd parity, DATA_W=7, STOP_BITS=2, PARITY=2: send 0x01 -> txd = 0,1,0,0,0,0,0,0,0(parity),1,1; 11 bits; busy high for 44 clocks.
- Back-to-back: two words pushed in consecutive cycles -> second start bit immediately follows the first stop bit, no idle high gap. frame_done pulses 44 clocks apart.
- Backpressure, tx_valid held high:
  - Without UART_TX_FIFO_EN: 2 words accepted before tx_ready drops.
  - With the macro and FIFO_DEPTH=4: 5 words accepted before tx_ready drops.
  - In both builds, tx_ready reasserts one clock after each pop.
- Reset mid-frame: assert rst low during DATA bit 3 -> txd = 1 and busy = 0 asynchronously; no frame_done. After release, tx_ready = 1 and the next pushed word transmits a clean frame.
- No parity, DATA_W=8, PARITY=0: send 0xFF -> 10-bit frame with the stop bit directly after bit 7; FSM never enters PARITY (check dbg_state).

Source files
------------

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake between a word source and uart_tx_param.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_W data LSB first, parity, stop).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module uart_tx_param #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_param_if.slave tx,
    output logic           txd,
    output logic           busy,
    output logic           frame_done,
    output logic [2:0]     dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    if (CLK_DIV < 2 || DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    logic              buf_full, buf_empty, push, pop;
    logic [DATA_W-1:0] buf_head;

    assign tx.tx_ready = rst & ~buf_full;
    assign push        = tx.tx_valid & tx.tx_ready;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wptr, rptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= tx.tx_data;
    end

    assign buf_empty = (wptr == rptr);
    assign buf_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign buf_head  = mem[rptr[AW-1:0]];
`else
    logic              hold_vld;
    logic [DATA_W-1:0] hold_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_vld <= push | (hold_vld & ~pop);
            if (push) hold_data <= tx.tx_data;
        end
    end

    assign buf_empty = ~hold_vld;
    assign buf_full  = hold_vld;
    assign buf_head  = hold_data;
`endif

    logic [2:0]        state;
    logic [CW-1:0]     baud_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              bit_end, last_data, last_stop, stop_exit;

    assign bit_end   = (baud_cnt == CW'(CLK_DIV - 1));
    assign last_data = (bit_cnt == BW'(DATA_W - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
    assign stop_exit = (state == S_STOP) && bit_end && last_stop;
    // Load from IDLE, or straight out of the last stop bit for gapless streaming.
    assign pop       = ~buf_empty & ((state == S_IDLE) | stop_exit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            baud_cnt <= ((state == S_IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                shreg   <= buf_head;
                par_bit <= (PARITY == 2) ? ~^buf_head : ^buf_head;
            end else if (state == S_DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
            case (state)
                S_IDLE:  if (!buf_empty) state <= S_START;
                S_START: if (bit_end) begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                end
                S_DATA:  if (bit_end) begin
                    bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                    if (last_data) state <= (PARITY != 0) ? S_PAR : S_STOP;
                end
                S_PAR:   if (bit_end) state <= S_STOP;
                S_STOP:  if (bit_end) begin
                    bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                    if (last_stop) state <= buf_empty ? S_IDLE : S_START;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line outputs are registered from the FSM state, so the line trails the state by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            busy       <= (state != S_IDLE);
            frame_done <= stop_exit;
            case (state)
                S_START: txd <= 1'b0;
                S_DATA:  txd <= shreg[0];
                S_PAR:   txd <= par_bit;
                default: txd <= 1'b1;
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8/even/1, 7/odd/2, 8/none/1) at CLK_DIV=4.
module tb_uart_tx_param;
    localparam int CD = 4;
`ifdef UART_TX_FIFO_EN
    localparam int EXP_ACC = 5;
`else
    localparam int EXP_ACC = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param_if #(.DATA_W(8)) if0 ();
    uart_tx_param_if #(.DATA_W(7)) if1 ();
    uart_tx_param_if #(.DATA_W(8)) if2 ();
    wire [2:0] txd, busy, fd;
    wire [2:0] dbg0, dbg1, dbg2;

    uart_tx_param #(.CLK_DIV(CD), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx(if0), .txd(txd[0]), .busy(busy[0]),
        .frame_done(fd[0]), .dbg_state(dbg0));
    uart_tx_param #(.CLK_DIV(CD), .DATA_W(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx(if1), .txd(txd[1]), .busy(busy[1]),
        .frame_done(fd[1]), .dbg_state(dbg1));
    uart_tx_param #(.CLK_DIV(CD), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx(if2), .txd(txd[2]), .busy(busy[2]),
        .frame_done(fd[2]), .dbg_state(dbg2));

    typedef struct { int dut; logic [15:0] bits; int len; } frm_t;
    typedef struct { int dut; logic [8:0] word; logic [15:0] bits; int len; } vec_t;

    int   checks = 0, failures = 0;
    frm_t sb_q[$];
    frm_t cur[3];
    int   k[3] = '{-1, -1, -1};
    logic [15:0] act[3];
    bit   bad[3], bad_busy[3], bad_fd[3], saw_par[3];
    int   start_cyc[3], prev_start[3], fd_cnt[3], last_fd[3], prev_fd[3], busy_cnt[3];
    int   acc_cyc;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    function automatic int flen(int d);
        return (d == 2) ? 10 : 11;
    endfunction

    // Reference frame: bit i of the result is the i-th bit on the line.
    function automatic logic [15:0] model(int d, logic [8:0] w);
        int dw, par, sb, idx;
        logic [15:0] b;
        logic x;
        dw  = (d == 1) ? 7 : 8;
        par = (d == 0) ? 1 : (d == 1) ? 2 : 0;
        sb  = (d == 1) ? 2 : 1;
        b   = '0;
        x   = 1'b0;
        for (int i = 0; i < dw; i++) begin
            b[1+i] = w[i];
            x ^= w[i];
        end
        idx = 1 + dw;
        if (par != 0) begin
            b[idx] = (par == 1) ? x : ~x;
            idx++;
        end
        for (int i = 0; i < sb; i++) b[idx+i] = 1'b1;
        return b;
    endfunction

    function automatic logic rdy(int d);
        case (d)
            0:       return if0.tx_ready;
            1:       return if1.tx_ready;
            default: return if2.tx_ready;
        endcase
    endfunction

    function automatic logic [2:0] dbg_of(int d);
        case (d)
            0:       return dbg0;
            1:       return dbg1;
            default: return dbg2;
        endcase
    endfunction

    task automatic drive(int d, logic [8:0] w, logic v);
        case (d)
            0:       begin if0.tx_data = w[7:0]; if0.tx_valid = v; end
            1:       begin if1.tx_data = w[6:0]; if1.tx_valid = v; end
            default: begin if2.tx_data = w[7:0]; if2.tx_valid = v; end
        endcase
    endtask

    task automatic sb_push(int d, logic [15:0] bits, int len);
        frm_t f;
        f.dut = d; f.bits = bits; f.len = len;
        sb_q.push_back(f);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(int d, logic [8:0] w, logic [15:0] bits, int len);
        int n = 0;
        drive(d, w, 1'b1);
        while (!rdy(d) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("send_ready_d%0d", d), rdy(d), 1);
        if (rdy(d)) begin
            sb_push(d, bits, len);
            acc_cyc = cyc + 1;
            @(negedge clk);
        end
        drive(d, w, 1'b0);
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        while ((sb_q.size() != 0 || k[d] >= 0 || busy[d] === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_d%0d", d), n < 3000, 1);
        @(negedge clk);
    endtask

    // Holds tx_valid high for ncyc cycles, counting the words taken.
    task automatic stream(int d, int ncyc, output int nacc);
        logic [8:0] w;
        nacc = 0;
        for (int i = 0; i < ncyc; i++) begin
            w = 9'h030 + 9'(nacc);
            drive(d, w, 1'b1);
            if (rdy(d)) begin
                sb_push(d, model(d, w), flen(d));
                nacc++;
            end
            @(negedge clk);
        end
    endtask

    // Line monitor: every clock of every frame is compared against the scoreboard head.
    initial begin
        int  bi;
        bit  ok;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (fd[g] === 1'b1) begin
                    fd_cnt[g]++;
                    prev_fd[g] = last_fd[g];
                    last_fd[g] = cyc;
                end
                if (!rst) begin
                    k[g] = -1;
                    continue;
                end
                if (busy[g] === 1'b1) busy_cnt[g]++;
                if (dbg_of(g) == 3'd3) saw_par[g] = 1'b1;
                if (k[g] < 0 && txd[g] === 1'b0) begin
                    prev_start[g] = start_cyc[g];
                    start_cyc[g]  = cyc;
                    ok = (sb_q.size() > 0) && (sb_q[0].dut == g);
                    chk($sformatf("frame_expected_d%0d", g), ok, 1);
                    if (ok) cur[g] = sb_q.pop_front();
                    else begin
                        cur[g].dut = g; cur[g].bits = '0; cur[g].len = 11;
                    end
                    k[g] = 0; act[g] = '0; bad[g] = 0; bad_busy[g] = 0; bad_fd[g] = 0;
                end
                if (k[g] >= 0) begin
                    bi = k[g] / CD;
                    if (txd[g] !== cur[g].bits[bi]) bad[g] = 1'b1;
                    if (k[g] % CD == CD / 2) act[g][bi] = txd[g];
                    if (busy[g] !== 1'b1) bad_busy[g] = 1'b1;
                    if (fd[g] !== (k[g] == cur[g].len * CD - 1)) bad_fd[g] = 1'b1;
                    k[g]++;
                    if (k[g] == cur[g].len * CD) begin
                        chk($sformatf("frame_bits_d%0d", g), {bad[g], act[g]}, {1'b0, cur[g].bits});
                        chk($sformatf("frame_busy_d%0d", g), bad_busy[g], 0);
                        chk($sformatf("frame_done_d%0d", g), bad_fd[g], 0);
                        k[g] = -1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[11];
        int   nacc, n, fdc, b0;
        logic [8:0] w;

        vt[0]  = '{0, 9'h0A5, 16'h054A, 11};
        vt[1]  = '{0, 9'h000, 16'h0400, 11};
        vt[2]  = '{0, 9'h0FF, 16'h05FE, 11};
        vt[3]  = '{0, 9'h001, 16'h0602, 11};
        vt[4]  = '{0, 9'h080, 16'h0700, 11};
        vt[5]  = '{1, 9'h001, 16'h0602, 11};
        vt[6]  = '{1, 9'h000, 16'h0700, 11};
        vt[7]  = '{1, 9'h07F, 16'h06FE, 11};
        vt[8]  = '{1, 9'h055, 16'h07AA, 11};
        vt[9]  = '{2, 9'h0FF, 16'h03FE, 10};
        vt[10] = '{2, 9'h03C, 16'h0278, 10};

        rst = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 9'h000, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 3'b111);
        chk("rst_busy", busy, 3'b000);
        chk("rst_frame_done", fd, 3'b000);
        chk("rst_ready", {rdy(2), rdy(1), rdy(0)}, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {rdy(2), rdy(1), rdy(0)}, 3'b111);
        chk("dbg_idle", {dbg2, dbg1, dbg0}, 9'd0);

        // First frame also measures accept-to-start latency.
        send(vt[0].dut, vt[0].word, vt[0].bits, vt[0].len);
        wait_idle(0);
        chk("latency", start_cyc[0] - acc_cyc, 2);

        for (int i = 1; i < 11; i++) begin
            send(vt[i].dut, vt[i].word, vt[i].bits, vt[i].len);
            wait_idle(vt[i].dut);
        end

        b0 = busy_cnt[1];
        send(1, 9'h001, model(1, 9'h001), flen(1));
        wait_idle(1);
        chk("busy_len_d1", busy_cnt[1] - b0, 44);

        send(0, 9'h03C, model(0, 9'h03C), flen(0));
        send(0, 9'h0C3, model(0, 9'h0C3), flen(0));
        wait_idle(0);
        chk("b2b_start_gap", start_cyc[0] - prev_start[0], 44);
        chk("b2b_fd_gap", last_fd[0] - prev_fd[0], 44);

        stream(0, 20, nacc);
        chk("bp_accepted", nacc, EXP_ACC);
        chk("bp_ready_low", rdy(0), 0);
        n = 0;
        while (fd[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_after_pop", rdy(0), 1);
        w = 9'h030 + 9'(nacc);
        drive(0, w, 1'b1);
        if (rdy(0)) sb_push(0, model(0, w), flen(0));
        @(negedge clk);
        drive(0, w, 1'b0);
        wait_idle(0);

        send(0, 9'h0A5, model(0, 9'h0A5), flen(0));
        send(0, 9'h05A, model(0, 9'h05A), flen(0));
        n = 0;
        while (k[0] < 18 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("dbg_in_data", dbg0, 3'd2);
        fdc = fd_cnt[0];
        #2 rst = 1'b0;
        #1;
        chk("async_rst_txd", txd[0], 1);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_ready", rdy(0), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_fd_on_abort", fd_cnt[0] - fdc, 0);
        chk("ready_after_abort", rdy(0), 1);
        chk("txd_idle_after_abort", txd[0], 1);
        send(0, 9'h03C, model(0, 9'h03C), flen(0));
        wait_idle(0);

        chk("no_parity_state_d2", saw_par[2], 0);
        chk("parity_state_d0", saw_par[0], 1);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
